// File: rtl/im_fetch_responder_pkg.sv
// im_fetch_responder_pkg: shared types and constants for the instruction fetch responder
package im_fetch_responder_pkg;
  localparam int InstructionBus = 32;
  localparam int InstructionAddrBus = 32;
  localparam logic [InstructionBus-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fetch_state_e;
endpackage

// File: rtl/im_fetch_responder_wait_counter.sv
// im_wait_counter: loadable down-counter that stops at zero and flags it
module im_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  // Load on request, otherwise count down towards zero and hold there
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/im_fetch_responder.sv
// im_fetch_responder: SRAM-backed responder for the IF-stage fetch port with wait states and flush
module im_fetch_responder
  import im_fetch_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = InstructionAddrBus,
  parameter int DATA_WIDTH  = InstructionBus,
  parameter int SRAM_AW     = 14,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_flush,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  output logic                  fetch_valid,
  output logic                  fetch_stall,
  output logic                  fetch_misalign,
  output logic [CNT_WIDTH-1:0]  fetch_count,
  output logic                  sram_cs,
  output logic [SRAM_AW-1:0]    sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);
  fetch_state_e state, state_nx;
  logic [SRAM_AW-1:0] word_q;
  logic drop, wait_zero, aligned, accept, unused_addr;
  assign aligned = fetch_addr[1:0] == 2'b00;
  assign accept = state == IDLE && fetch_req;
  assign unused_addr = ^fetch_addr[ADDR_WIDTH-1:SRAM_AW+2];
  assign sram_addr = word_q;
  im_wait_counter #(.W(4)) u_wait (
    .clk(clk),
    .rst(rst),
    .load(state == ISSUE),
    .load_val(4'(WAIT_CYCLES)),
    .zero(wait_zero)
  );
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Next state: misaligned requests skip the SRAM and answer straight away
  always_comb
    state_nx = state == IDLE  ? (fetch_req ? (aligned ? ISSUE : RESP) : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (wait_zero ? RESP : WAIT) : IDLE;
  // Outputs decoded from state; a flush during RESP still silences the pulse
  always_comb begin
    sram_cs = state == ISSUE;
    fetch_valid = state == RESP && !drop && !fetch_flush;
    fetch_stall = accept || state == ISSUE || state == WAIT;
  end
  // Address latch, response capture, drop flag and delivered counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_q <= '0;
      fetch_rdata <= '0;
      fetch_misalign <= 1'b0;
      drop <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (accept) word_q <= fetch_addr[SRAM_AW+1:2];
      if (accept && !aligned) begin
        fetch_rdata <= DATA_WIDTH'(NOP_INSTR);
        fetch_misalign <= 1'b1;
      end else if (state == WAIT && wait_zero) begin
        fetch_rdata <= sram_rdata;
        fetch_misalign <= 1'b0;
      end
      if ((state == ISSUE || state == WAIT) && fetch_flush) drop <= 1'b1;
      else if (state == RESP) drop <= 1'b0;
      if (fetch_valid) fetch_count <= fetch_count + 1'b1;
    end
endmodule

// File: tb/tb_im_fetch_responder.sv
// tb_im_fetch_responder: randomized transaction-level check of im_fetch_responder
module tb_im_fetch_responder;
  localparam int WC = 3;
  localparam int CW = 4;
  logic clk = 0, rst = 1, fetch_req = 0, fetch_flush = 0;
  logic [31:0] fetch_addr = 0, sram_rdata = 0, fetch_rdata;
  logic fetch_valid, fetch_stall, fetch_misalign, sram_cs;
  logic [CW-1:0] fetch_count;
  logic [13:0] sram_addr;
  int total = 0, passed = 0, model_cnt = 0;
  int cyc = 0, cs_edge = -100;
  logic [13:0] sa = 0;

  im_fetch_responder #(.WAIT_CYCLES(WC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_flush(fetch_flush), .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid),
    .fetch_stall(fetch_stall), .fetch_misalign(fetch_misalign), .fetch_count(fetch_count),
    .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [13:0] a);
    return a == 14'd4 ? 32'h00A0_0093 : 32'h9E37_79B9 * (32'(a) + 1);
  endfunction

  function automatic int lat(input logic [31:0] a);
    return a[1:0] != 2'b00 ? 1 : 3 + WC;
  endfunction

  // SRAM model: data appears only in the single cycle the read becomes valid
  always @(posedge clk) begin
    if (sram_cs) begin
      cs_edge = cyc;
      sa = sram_addr;
    end
    sram_rdata <= (cyc == cs_edge + WC) ? word(sa) : 32'hDEAD_BEEF;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One fetch transaction; fk is the cycle (0 = request cycle) holding a flush pulse, -1 for none
  task automatic run_fetch(input logic [31:0] a, input int fk);
    int end_k, cs_cnt, cs_k, vcnt;
    logic [13:0] cs_a;
    logic [31:0] rd;
    logic mis, vend, deliver, mal;
    int exp_end;
    exp_end = lat(a);
    mal = a[1:0] != 2'b00;
    deliver = !(fk >= 1 && fk <= exp_end);
    end_k = -1; cs_cnt = 0; cs_k = -1; vcnt = 0; cs_a = 0; rd = 0; mis = 0; vend = 0;
    @(negedge clk);
    fetch_req = 1; fetch_addr = a; fetch_flush = fk == 0;
    #1 check("stall_req", fetch_stall, 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      fetch_flush = k == fk;
      #1;
      if (sram_cs) begin cs_cnt++; cs_k = k; cs_a = sram_addr; end
      if (fetch_valid) vcnt++;
      if (!fetch_stall) begin
        end_k = k; rd = fetch_rdata; mis = fetch_misalign; vend = fetch_valid;
        fetch_req = 0;
        break;
      end
    end
    if (end_k < 0) fetch_req = 0;
    @(negedge clk);
    fetch_flush = 0;
    if (deliver) model_cnt = (model_cnt + 1) % (1 << CW);
    #1;
    check("latency", end_k, exp_end);
    check("valid_pulses", vcnt, 32'(deliver));
    check("valid_in_resp", vend, deliver);
    check("cs_count", cs_cnt, mal ? 0 : 1);
    if (!mal) begin
      check("cs_cycle", cs_k, 1);
      check("sram_addr", cs_a, a[15:2]);
    end
    check("rdata", rd, mal ? 32'h0000_0013 : word(a[15:2]));
    check("misalign", mis, mal);
    check("count", fetch_count, model_cnt);
    check("idle_valid", fetch_valid, 0);
  endtask

  initial begin
    int vcnt, r, fk, e;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", fetch_valid, 0);
    check("rst_cs", sram_cs, 0);
    check("rst_rdata", fetch_rdata, 0);
    check("rst_count", fetch_count, 0);
    check("rst_stall", fetch_stall, 0);
    rst = 0;
    run_fetch(32'h10, -1);
    run_fetch(32'h100, -1);
    run_fetch(32'h6, -1);
    run_fetch(32'h100, 3);
    run_fetch(32'h20, -1);
    run_fetch(32'h44, 0);
    run_fetch(32'h48, lat(32'h48));
    for (int i = 0; i < 40; i++) begin
      a = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      e = lat(a);
      r = $urandom_range(0, 3);
      fk = r == 0 ? -1 : r == 1 ? 0 : r == 2 ? (e > 1 ? $urandom_range(1, e - 1) : 1) : e;
      run_fetch(a, fk);
    end
    @(negedge clk);
    fetch_req = 1; fetch_addr = 32'h40;
    @(negedge clk);
    #1 check("cs_before_rst", sram_cs, 1);
    fetch_req = 0; rst = 1;
    #1;
    check("rst_mid_cs", sram_cs, 0);
    check("rst_mid_valid", fetch_valid, 0);
    check("rst_mid_stall", fetch_stall, 0);
    check("rst_mid_count", fetch_count, 0);
    check("rst_mid_rdata", fetch_rdata, 0);
    check("rst_mid_mis", fetch_misalign, 0);
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1 if (fetch_valid || sram_cs) vcnt++;
    end
    check("post_rst_quiet", vcnt, 0);
    for (int i = 0; i < 17; i++) run_fetch(32'(i) << 2, -1);
    check("count_wrap", fetch_count, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
